// File: rtl/freqmeter_channel.sv
// Reciprocal frequency channel: counts clk_i cycles spanning N whole fin_i periods; edges lag fin_i by SYNC_STAGES+1 cycles.
// No backpressure: result registers are latched on entry to DONE with a one-cycle ready_o pulse; start_i is dropped while busy.
module freqmeter_channel #(
   parameter int                   CNT_WIDTH   = 32,
   parameter int                   PER_WIDTH   = 16,
   parameter int                   SYNC_STAGES = 2,
   parameter logic [CNT_WIDTH-1:0] TIMEOUT     = {CNT_WIDTH{1'b1}}
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 fin_i,
   input  logic                 start_i,
   input  logic [PER_WIDTH-1:0] target_periods_i,
   output logic                 busy_o,
   output logic                 ready_o,
   output logic                 timeout_o,
   output logic [CNT_WIDTH-1:0] clock_count_o,
   output logic [PER_WIDTH-1:0] period_count_o
);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   fin_edge;
   logic [PER_WIDTH-1:0]   n_target;
   logic [CNT_WIDTH-1:0]   clk_cnt;
   logic [CNT_WIDTH-1:0]   clk_inc;
   logic [PER_WIDTH-1:0]   per_cnt;
   logic [PER_WIDTH-1:0]   per_inc;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], fin_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign fin_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign clk_inc  = clk_cnt + CNT_WIDTH'(1);
   assign per_inc  = per_cnt + PER_WIDTH'(1);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state          <= IDLE;
         n_target       <= '0;
         clk_cnt        <= '0;
         per_cnt        <= '0;
         busy_o         <= 1'b0;
         ready_o        <= 1'b0;
         timeout_o      <= 1'b0;
         clock_count_o  <= '0;
         period_count_o <= '0;
      end else begin
         ready_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  // A zero target would never complete, so it measures one period instead.
                  n_target <= (target_periods_i == '0) ? PER_WIDTH'(1) : target_periods_i;
                  clk_cnt  <= '0;
                  per_cnt  <= '0;
                  busy_o   <= 1'b1;
                  state    <= ARM;
               end
            end
            ARM: begin
               if (fin_edge) begin
                  clk_cnt <= '0;
                  per_cnt <= '0;
                  state   <= MEASURE;
               end else if (clk_cnt == TIMEOUT) begin
                  clock_count_o  <= '0;
                  period_count_o <= '0;
                  timeout_o      <= 1'b1;
                  busy_o         <= 1'b0;
                  ready_o        <= 1'b1;
                  state          <= DONE;
               end else begin
                  clk_cnt <= clk_inc;
               end
            end
            MEASURE: begin
               clk_cnt <= clk_inc;
               if (fin_edge)
                  per_cnt <= per_inc;
               // A completing edge wins over a coincident timeout.
               if (fin_edge && per_inc == n_target) begin
                  clock_count_o  <= clk_inc;
                  period_count_o <= n_target;
                  timeout_o      <= 1'b0;
                  busy_o         <= 1'b0;
                  ready_o        <= 1'b1;
                  state          <= DONE;
               end else if (clk_inc == TIMEOUT) begin
                  clock_count_o  <= TIMEOUT;
                  period_count_o <= fin_edge ? per_inc : per_cnt;
                  timeout_o      <= 1'b1;
                  busy_o         <= 1'b0;
                  ready_o        <= 1'b1;
                  state          <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/freqmeter_channel.md
Name: freqmeter_channel

Overview:
Single-channel reciprocal frequency measurement front-end, one instance per Fin[n] input of the frequency meter.
- Synchronises an asynchronous measured signal into the system clock domain and detects its rising edges.
- Counts the exact number of system clock cycles spanning a programmed number of whole input periods.
- Presents the result to the CPU-side register block with a one-cycle ready pulse; a timeout flags dead or too-slow inputs.

Parameters:
CNT_WIDTH, 32, width of the reference clock-cycle counter and of clock_count_o.
PER_WIDTH, 16, width of the period target and of period_count_o.
SYNC_STAGES, 2, number of synchroniser flops on fin_i (minimum 2).
TIMEOUT, 2**CNT_WIDTH-1, clock-cycle count at which a measurement is abandoned.

Ports:
clk_i  in  1  system clock; all logic on its rising edge.
rst_i  in  1  reset; asynchronous, active-low.
fin_i  in  1  measured signal; asynchronous to clk_i.
start_i  in  1  one-cycle request to begin a measurement; ignored while busy_o=1.
target_periods_i  in  PER_WIDTH  number of input periods to span; sampled on accepted start_i.
busy_o  out  1  measurement in progress (ARM or MEASURE state).
ready_o  out  1  one-cycle pulse when a new result is latched.
timeout_o  out  1  latched with the result: 1 = measurement ended by TIMEOUT.
clock_count_o  out  CNT_WIDTH  clk_i cycles between the first and last counted rising edges.
period_count_o  out  PER_WIDTH  rising-edge intervals actually spanned.

Behaviour:
Reset:
- Asynchronous assert (rst_i=0). All outputs 0, synchroniser flops 0, state IDLE.
- Release is used synchronously; no edge is detected in the first cycle after release.

Edge detect:
- fin_i passes through SYNC_STAGES flops, then one history flop.
- edge = sync_out & ~hist.
- Fixed latency of SYNC_STAGES+1 cycles, identical for every edge, so it cancels in the difference.

FSM states:
- IDLE:
  - busy_o=0.
  - On start_i: load N = target_periods_i; N=0 is treated as 1. Go to ARM.
- ARM:
  - busy_o=1; clk_cnt counts every cycle from 0 for timeout purposes.
  - On edge: clk_cnt<=0, per_cnt<=0, go to MEASURE.
  - If clk_cnt reaches TIMEOUT before an edge: latch clock_count_o=0, period_count_o=0, timeout_o=1, go to DONE.
- MEASURE:
  - clk_cnt increments every cycle.
  - On edge, per_cnt increments.
  - When an edge makes per_cnt+1 == N: latch clock_count_o=clk_cnt+1, period_count_o=N, timeout_o=0, go to DONE.
  - If clk_cnt+1 reaches TIMEOUT first: latch clock_count_o=TIMEOUT, period_count_o=per_cnt (periods completed so far), timeout_o=1, go to DONE.
  - An edge in the same cycle as timeout takes priority: the period completes normally.
- DONE:
  - ready_o=1 for exactly this cycle, busy_o=0, unconditional return to IDLE.
  - A start_i in DONE is ignored.

Output rules:
- Output registers hold their values until the next latch.
- They change only in the cycle entering DONE.
- Counters saturate and never wrap; no arithmetic overflow is possible because of TIMEOUT.

Reset mid-operation:
- Any state returns immediately to IDLE.
- No ready_o pulse is produced; latched results are cleared.

Input edge cases:
- A fin_i held constant produces no edges; the measurement ends only via TIMEOUT.
- A fin_i faster than clk_i/2 is undersampled; this is not detected by design.

Test Plan:
1. Reset release, fin_i idle -> all outputs 0, busy_o=0, no ready_o for 100 cycles.
2. fin_i = clk_i/32 square wave, start_i with target=4 -> busy_o high; ready_o pulse; clock_count_o=128, period_count_o=4, timeout_o=0.
3. fin_i = clk_i/20 (high 7, low 13), target=0 -> treated as 1; clock_count_o=20, period_count_o=1.
4. TIMEOUT overridden to 1000, fin_i stuck at 0, start_i -> ready_o exactly 1000+1 cycles after start_i; timeout_o=1, clock_count_o=0, period_count_o=0.
5. TIMEOUT=1000, fin_i period 300, target=10 -> timeout_o=1, clock_count_o=1000, period_count_o=3.
6. start_i pulsed again while busy, then rst_i=0 mid-MEASURE -> second start ignored; on reset outputs immediately 0, state IDLE, no ready_o; next start measures correctly (clock_count_o=128 for case 2 stimulus).
